// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer:
//   - opcode constants understood by the attached ALU
//   - FSM state encoding (plain 2-bit constants)
//   - debug status struct exported by the top level
//   - is_legal_op(): opcode legality check used at issue time
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   // Native opcode width of the ALU command set.
   localparam int OPC_W = 4;

   // Opcodes accepted by the ALU. Every other encoding is rejected.
   localparam logic [OPC_W-1:0] OP_A    = 4'h0;  // pass A
   localparam logic [OPC_W-1:0] OP_B    = 4'h1;  // pass B
   localparam logic [OPC_W-1:0] OP_SUM  = 4'h2;  // A + B
   localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;  // A - B
   localparam logic [OPC_W-1:0] OP_CMUL = 4'h4;  // complex multiply
   localparam logic [OPC_W-1:0] OP_RMUL = 4'h6;  // real multiply
   localparam logic [OPC_W-1:0] OP_EQ   = 4'h8;  // A == B
   localparam logic [OPC_W-1:0] OP_MODA = 4'h9;  // |A|
   localparam logic [OPC_W-1:0] OP_MODB = 4'hA;  // |B|

   // FSM state encoding. The fourth code (2'b11) is unreachable and
   // recovers to IDLE.
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_WAIT  = 2'b01;
   localparam logic [1:0] ST_FLUSH = 2'b10;

   // Debug view of the sequencer: current state and whether the
   // timeout counter has reached its limit.
   typedef struct packed {
      logic [1:0] state;
      logic       expired;
   } seq_dbg_t;

   // Opcode legality. The argument is zero-extended from the port width,
   // so any set bit above the native 4-bit field makes the opcode illegal.
   function automatic logic is_legal_op(input logic [15:0] op);
      logic legal;
      legal = 1'b0;
      if (op[15:OPC_W] == '0) begin
         case (op[OPC_W-1:0])
            OP_A, OP_B, OP_SUM, OP_SUB, OP_CMUL,
            OP_RMUL, OP_EQ, OP_MODA, OP_MODB: legal = 1'b1;
            default:                          legal = 1'b0;
         endcase
      end
      return legal;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Connection between the sequencer (master) and the ALU (slave).
//
//   alu_go      master -> slave  one-cycle issue strobe
//   alu_op      master -> slave  opcode, stable from alu_go until completion
//   done        slave  -> master one-cycle completion strobe
//   alu_result  slave  -> master result, meaningful only while done = 1
//
// Handshake: the master raises alu_go for exactly one cycle per operation
// and holds alu_op stable afterwards. The slave answers with a single done
// pulse carrying alu_result in the same cycle. The master accepts done only
// while it is waiting for that operation; a done arriving at any other time
// (after an abort, a timeout or a reset) is dropped. There is no
// backpressure in either direction.
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
   parameter int DW  = 64,
   parameter int OPW = 4
);
   logic           alu_go;
   logic [OPW-1:0] alu_op;
   logic           done;
   logic [DW-1:0]  alu_result;

   modport master (
      output alu_go,
      output alu_op,
      input  done,
      input  alu_result
   );

   modport slave (
      input  alu_go,
      input  alu_op,
      output done,
      output alu_result
   );
endinterface

// File: rtl/alu_seq_timer.sv
// -----------------------------------------------------------------------------
// alu_seq_timer
// Timeout limit register plus cycle counter for one outstanding operation.
//
//   clock     rising-edge clock
//   reset     asynchronous active-low reset (limit and count cleared)
//   load      capture limit_in and clear the count
//   limit_in  timeout limit sampled on load
//   enable    advance the count by one
//   expired   count equals the captured limit
//
// load has priority over enable. The count never passes the limit because
// the sequencer stops enabling it once expired is seen.
// -----------------------------------------------------------------------------
module alu_seq_timer #(
   parameter int TW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic [TW-1:0] limit_in,
   input  logic          enable,
   output logic          expired
);

   logic [TW-1:0] limit_q;
   logic [TW-1:0] count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         limit_q <= '0;
         count_q <= '0;
      end else if (load) begin
         limit_q <= limit_in;
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + TW'(1);
      end
   end

   assign expired = (count_q == limit_q);

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Issues one operation at a time to an ALU and waits for its completion,
// with abort and a per-operation timeout.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   start      issue request, honoured only in IDLE
//   opr        requested opcode, sampled with start
//   maxcycles  timeout limit, sampled with start
//   abort      cancel the outstanding operation
//   alu        master side of alu_sequencer_if (alu_go/alu_op out,
//              done/alu_result in)
//   out        last successfully completed result
//   valid      one-cycle pulse when out has been updated
//   busy       registered (state != IDLE)
//   timeout    one-cycle pulse when an operation timed out
//   illegal    one-cycle pulse when start carried an illegal opcode
//   dbg        current state and timer expiry, for observation only
//
// FSM
//   IDLE  --start & legal-->  WAIT
//   WAIT  --abort--> IDLE, --done--> IDLE, --expired--> FLUSH, else count
//   FLUSH --------> IDLE  (one cycle; swallows a late done)
// All outputs come straight from flops; pulses are registered from the
// decision made in the previous cycle.
// -----------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DW  = 64,
   parameter int OPW = 4,
   parameter int TW  = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [OPW-1:0] opr,
   input  logic [TW-1:0]  maxcycles,
   input  logic           abort,
   alu_sequencer_if.master alu,
   output logic [DW-1:0]  out,
   output logic           valid,
   output logic           busy,
   output logic           timeout,
   output logic           illegal,
   output seq_dbg_t       dbg
);

   logic [1:0]     state;
   logic [1:0]     state_nxt;
   logic           go_q;
   logic [OPW-1:0] op_q;

   logic opr_legal;
   logic accept;       // start taken: enter WAIT
   logic reject;       // start refused: pulse illegal
   logic in_wait;
   logic take_done;    // completion accepted this cycle
   logic take_to;      // limit reached without completion
   logic timer_en;
   logic timer_expired;

   assign opr_legal = is_legal_op(16'(opr));
   assign accept    = (state == ST_IDLE) && start &&  opr_legal;
   assign reject    = (state == ST_IDLE) && start && !opr_legal;
   assign in_wait   = (state == ST_WAIT);

   // WAIT resolution order: abort, then done, then timeout, then count.
   assign take_done = in_wait && !abort &&  alu.done;
   assign take_to   = in_wait && !abort && !alu.done &&  timer_expired;
   assign timer_en  = in_wait && !abort && !alu.done && !timer_expired;

   alu_seq_timer #(
      .TW (TW)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (accept),
      .limit_in (maxcycles),
      .enable   (timer_en),
      .expired  (timer_expired)
   );

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE: begin
            state_nxt = accept ? ST_WAIT : ST_IDLE;
         end
         ST_WAIT: begin
            if (abort || alu.done) begin
               state_nxt = ST_IDLE;
            end else if (timer_expired) begin
               state_nxt = ST_FLUSH;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_FLUSH: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         go_q    <= 1'b0;
         op_q    <= '0;
         out     <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         // busy is computed from the next state so that it lines up
         // cycle-for-cycle with the registered state.
         busy    <= (state_nxt != ST_IDLE);
         go_q    <= accept;
         illegal <= reject;
         valid   <= take_done;
         timeout <= take_to;
         if (accept) begin
            op_q <= opr;
         end
         if (take_done) begin
            out <= alu.alu_result;
         end
      end
   end

   assign alu.alu_go  = go_q;
   assign alu.alu_op  = op_q;

   assign dbg.state   = state;
   assign dbg.expired = timer_expired;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed scenarios for alu_sequencer. Each issued operation pushes its
// expected pulse (alu_go, valid, timeout or illegal with the associated
// value) into exp_q; a negedge monitor pops and compares every pulse the
// DUT produces. The driver additionally checks levels at fixed cycles.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int DW  = 64;
   localparam int OPW = 4;
   localparam int TW  = 8;

   localparam logic [1:0] K_GO    = 2'd0;
   localparam logic [1:0] K_VALID = 2'd1;
   localparam logic [1:0] K_TO    = 2'd2;
   localparam logic [1:0] K_ILL   = 2'd3;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic           start     = 1'b0;
   logic [OPW-1:0] opr       = '0;
   logic [TW-1:0]  maxcycles = '0;
   logic           abort     = 1'b0;
   logic [DW-1:0]  out;
   logic           valid;
   logic           busy;
   logic           timeout;
   logic           illegal;
   seq_dbg_t       dbg;

   alu_sequencer_if #(.DW(DW), .OPW(OPW)) alu ();

   alu_sequencer #(
      .DW  (DW),
      .OPW (OPW),
      .TW  (TW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .opr       (opr),
      .maxcycles (maxcycles),
      .abort     (abort),
      .alu       (alu),
      .out       (out),
      .valid     (valid),
      .busy      (busy),
      .timeout   (timeout),
      .illegal   (illegal),
      .dbg       (dbg)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [DW+1:0] exp_q[$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic sb_compare(input string name, input logic [DW+1:0] act);
      logic [DW+1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected pulse actual=%h required=none", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, e);
         end
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         if (alu.alu_go) sb_compare("alu_go",  {K_GO, DW'(alu.alu_op)});
         if (valid)      sb_compare("valid",   {K_VALID, out});
         if (timeout)    sb_compare("timeout", {K_TO, out});
         if (illegal)    sb_compare("illegal", {K_ILL, {DW{1'b0}}});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   // Present start for one cycle; returns in the cycle after it was sampled.
   task automatic issue(input logic [OPW-1:0] op, input logic [TW-1:0] mc, input logic legal);
      start     = 1'b1;
      opr       = op;
      maxcycles = mc;
      if (legal) exp_q.push_back({K_GO, DW'(op)});
      else       exp_q.push_back({K_ILL, {DW{1'b0}}});
      tick();
      start     = 1'b0;
      opr       = '0;
      maxcycles = '0;
   endtask

   task automatic alu_done(input logic [DW-1:0] res);
      alu.done       = 1'b1;
      alu.alu_result = res;
   endtask

   task automatic alu_idle();
      alu.done       = 1'b0;
      alu.alu_result = '0;
   endtask

   // ---------------- stimulus ----------------
   int v1;

   initial begin
      alu_idle();

      // Reset: outputs forced low immediately.
      #2 reset = 1'b0;
      #1;
      check("rst out",     out,                   64'h0);
      check("rst valid",   DW'(valid),            64'h0);
      check("rst busy",    DW'(busy),             64'h0);
      check("rst alu_go",  DW'(alu.alu_go),       64'h0);
      check("rst alu_op",  DW'(alu.alu_op),       64'h0);
      check("rst timeout", DW'(timeout),          64'h0);
      check("rst illegal", DW'(illegal),          64'h0);
      check("rst state",   DW'(dbg.state),        64'h0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      tick();

      // Sum, done on the 3rd WAIT cycle with result 0xFF.
      issue(4'h2, 8'd8, 1'b1);
      at_neg();
      check("sum busy wait1", DW'(busy),       64'h1);
      check("sum alu_op",     DW'(alu.alu_op), 64'h2);
      tick();
      tick();
      exp_q.push_back({K_VALID, 64'hFF});
      alu_done(64'hFF);
      tick();
      alu_idle();
      at_neg();
      check("sum valid", DW'(valid), 64'h1);
      check("sum out",   out,        64'hFF);
      check("sum busy",  DW'(busy),  64'h0);
      tick();

      // Illegal opcode 0101.
      issue(4'h5, 8'd8, 1'b0);
      at_neg();
      check("ill pulse",  DW'(illegal),    64'h1);
      check("ill busy",   DW'(busy),       64'h0);
      check("ill alu_go", DW'(alu.alu_go), 64'h0);
      tick();
      at_neg();
      check("ill one cycle", DW'(illegal), 64'h0);
      check("ill busy2",     DW'(busy),    64'h0);
      tick();

      // Timeout with maxcycles=3; late done in FLUSH ignored.
      issue(4'h6, 8'd3, 1'b1);
      tick();
      tick();
      tick();
      at_neg();
      check("to not yet wait4", DW'(timeout), 64'h0);
      check("to busy wait4",    DW'(busy),    64'h1);
      exp_q.push_back({K_TO, 64'hFF});
      tick();
      alu_done(64'h1234);
      at_neg();
      check("to pulse",      DW'(timeout),   64'h1);
      check("to flush",      DW'(dbg.state), 64'h2);
      tick();
      alu_idle();
      at_neg();
      check("to out kept",   out,         64'hFF);
      check("to busy after", DW'(busy),   64'h0);
      check("to no valid",   DW'(valid),  64'h0);
      tick();

      // Timeout with maxcycles=0: first WAIT cycle.
      issue(4'h9, 8'd0, 1'b1);
      exp_q.push_back({K_TO, 64'hFF});
      tick();
      at_neg();
      check("to0 pulse", DW'(timeout), 64'h1);
      tick();
      tick();

      // Abort and done together: abort wins.
      issue(4'h1, 8'd8, 1'b1);
      alu_done(64'hDEAD);
      abort = 1'b1;
      tick();
      alu_idle();
      abort = 1'b0;
      at_neg();
      check("abort busy",  DW'(busy),      64'h0);
      check("abort valid", DW'(valid),     64'h0);
      check("abort out",   out,            64'hFF);
      check("abort state", DW'(dbg.state), 64'h0);
      tick();

      // Back-to-back: done on first WAIT cycle, restart right after valid.
      issue(4'h3, 8'd5, 1'b1);
      exp_q.push_back({K_VALID, 64'h0123_4567_89AB_CDEF});
      alu_done(64'h0123_4567_89AB_CDEF);
      tick();
      alu_idle();
      at_neg();
      check("b2b valid1", DW'(valid), 64'h1);
      v1 = cyc;
      tick();
      issue(4'h4, 8'd5, 1'b1);
      exp_q.push_back({K_VALID, 64'hFEDC_BA98_7654_3210});
      alu_done(64'hFEDC_BA98_7654_3210);
      tick();
      alu_idle();
      at_neg();
      check("b2b valid2",  DW'(valid),    64'h1);
      check("b2b spacing", DW'(cyc - v1), 64'h3);
      check("b2b out",     out,           64'hFEDC_BA98_7654_3210);
      tick();

      // start while in WAIT is ignored; opcode is not re-sampled.
      issue(4'h2, 8'd10, 1'b1);
      start     = 1'b1;
      opr       = 4'h6;
      maxcycles = 8'd1;
      tick();
      start     = 1'b0;
      opr       = '0;
      maxcycles = '0;
      at_neg();
      check("ign alu_op", DW'(alu.alu_op), 64'h2);
      check("ign busy",   DW'(busy),       64'h1);
      exp_q.push_back({K_VALID, 64'h77});
      alu_done(64'h77);
      tick();
      alu_idle();
      at_neg();
      check("ign out", out, 64'h77);
      tick();

      // Reset mid-WAIT, then a stray done after release.
      issue(4'h8, 8'd20, 1'b1);
      tick();
      reset = 1'b0;
      #1;
      check("mid rst out",    out,            64'h0);
      check("mid rst busy",   DW'(busy),      64'h0);
      check("mid rst alu_op", DW'(alu.alu_op), 64'h0);
      check("mid rst state",  DW'(dbg.state), 64'h0);
      tick();
      reset = 1'b1;
      alu_done(64'h55);
      tick();
      alu_idle();
      at_neg();
      check("post rst valid", DW'(valid), 64'h0);
      check("post rst out",   out,        64'h0);
      check("post rst busy",  DW'(busy),  64'h0);
      repeat (3) tick();

      check("exp_q drained", DW'(exp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
